lane_permuter: RTL and testbench
================================

# lane_permuter

Parametrised lane permutation engine for the AUI lane-striping path. It re-orders `NUM_LANES` lanes of `LANE_WIDTH` bits per cycle through a registered crossbar in one of four modes: bypass, rotate, permute or inverse-permute. The permutation is generated on-chip by a seeded, deterministic LFSR-driven Fisher–Yates FSM and can be regenerated at run time without stalling traffic. Inverse mode lets a second instance undo the shuffle, so TX/RX loopback tests need no external map.

## Interface

- `NUM_LANES`, 16: lane count, 2..64.
- `LANE_WIDTH`, 1360: bits per lane.
- `SEED`, 32'h1: LFSR value loaded at reset.
- `IDX_W`, $clog2(NUM_LANES): lane index width (derived, do not override).

- `i_clk`  in  1: clock.
- `i_rst`  in  1: synchronous reset, active-high.
- `i_valid`  in  1: input word valid.
- `i_data`  in  [LANE_WIDTH-1:0] x NUM_LANES: input lanes (unpacked array).
- `i_mode`  in  2: 0 bypass, 1 rotate, 2 permute, 3 inverse.
- `i_rot`  in  IDX_W: rotate amount for mode 1.
- `i_regen`  in  1: single-cycle pulse; start a permutation generation.
- `i_seed_load`  in  1: load `i_seed` into the LFSR.
- `i_seed`  in  32: seed value.
- `o_valid`  out  1: output word valid.
- `o_data`  out  [LANE_WIDTH-1:0] x NUM_LANES: output lanes.
- `o_busy`  out  1: generation in progress.
- `o_map`  out  IDX_W x NUM_LANES: active map, exported for the descrambler and debug.

## Operation

- Datapath modes, with `map` = active map:
  - mode 0: `o[j]=i[j]`.
  - mode 1: `o[j]=i[(j+i_rot) mod NUM_LANES]`.
  - mode 2: `o[j]=i[map[j]]`.
  - mode 3: `o[map[j]]=i[j]`.
- Mode and rot are sampled in the same cycle as `i_valid`.
- When `i_valid`=0, `o_data` holds its previous value.
- LFSR: 32-bit Galois, polynomial 0x80200003, shifts right.
  - It advances exactly once per SHUF cycle and never otherwise.
  - A seed of 0, from either `i_seed` or `SEED`, is replaced by 1.
- Generation FSM states are IDLE, INIT, SHUF and COMMIT.
- IDLE:
  - `i_regen` moves the FSM to INIT.
  - `i_seed_load` loads the LFSR.
  - If both are asserted together, the seed is loaded first and used by this generation.
- INIT: shadow map is set to identity; counter `k` is set to NUM_LANES-1. Go to SHUF.
- SHUF, one swap per cycle:
  - `r = lfsr[IDX_W-1:0] & m(k)`, where `m(k)` = all-ones of width $clog2(k+1).
  - `j = (r>k) ? r-(k+1) : r`.
  - Swap `shadow[k]` and `shadow[j]`, then decrement `k`.
  - Go to COMMIT after processing `k`=1.
- COMMIT: active map is loaded from shadow in a single cycle. Go to IDLE.
- `o_busy`=1 in INIT, SHUF and COMMIT.
- `i_regen` and `i_seed_load` are ignored while busy.
- Traffic uses the old active map until the COMMIT edge. No word is ever built from a mixed map.
- After reset release the FSM leaves IDLE for INIT automatically, once. A fresh map is produced per reset, reproducibly from `SEED`.

## Timing

- Datapath latency is 1 cycle: `o_valid`(t+1) = `i_valid`(t).
- A word whose `i_valid` is in the COMMIT cycle uses the old map. The next word uses the new one.
- Generation takes NUM_LANES+1 cycles from the INIT cycle through COMMIT inclusive; this is 17 for N=16.
- Reset values:
  - `o_valid`=0, `o_data`=0, `o_busy`=0.
  - Active and shadow maps = identity, so `o_map[j]=j`.
  - LFSR=`SEED` (0→1), state=IDLE.
- Reset mid-generation:
  - The partial shadow map is discarded and the active map becomes identity.
  - The automatic generation restarts after reset release.
- `i_rot`=0 in mode 1 is equivalent to bypass.

## Structure

- Package `lane_perm_pkg`:
  - `mode_t` enum: BYPASS, ROTATE, PERMUTE, INVERSE.
  - `gen_state_t` enum.
  - `LFSR_POLY` constant.
  - Function `idx_mask(k)`.
- Sub-module `lane_perm_lfsr`: 32-bit Galois LFSR with load, advance and zero-seed guard.
- Crossbar and FSM live in `lane_permuter`.

## Test plan

- Bypass: N=16, `i_data[j]`=j, mode 0, `i_valid`=1 → next cycle `o_data[j]`=j, `o_valid`=1.
- Rotate: `i_rot`=1, `i_data[j]`=j → `o_data[j]`=(j+1) mod 16, so `o_data[15]`=0. With `i_rot`=15 → `o_data[0]`=15.
- Generation after reset with `SEED`=1:
  - `o_busy` is high for exactly 17 cycles.
  - `o_map` afterwards is a permutation of 0..15 and matches the bench reference model bit-exact.
  - A second reset reproduces the same map.
- Loopback: instance A in mode 2 feeds instance B in mode 3, both with the same seed, over 1000 random words → B output equals A input, with 2-cycle latency. This also holds across a regen on both.
- Hitless regen:
  - Stream continuous words and pulse `i_regen`.
  - Words up to and including the COMMIT cycle use the old map; words after use the new map.
  - A second `i_regen` pulsed while busy is ignored, so there is no extra busy period.
- Reset mid-SHUF (k=8) → `o_map` is identity in the cycle after reset, `o_valid`=0, and a full 17-cycle generation follows. `i_seed`=0 with load behaves exactly as seed 1.

Source files
------------

// File: rtl/lane_perm_pkg.sv
// Shared types, constants and helpers for the lane permutation engine.
package lane_perm_pkg;

    typedef enum logic [1:0] {
        BYPASS  = 2'd0,
        ROTATE  = 2'd1,
        PERMUTE = 2'd2,
        INVERSE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StShuf,
        StCommit
    } gen_state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // All-ones mask covering the bit length of k, i.e. $clog2(k+1) ones.
    function automatic int unsigned idx_mask(input int unsigned k);
        int unsigned m;
        m = 0;
        for (int b = 0; b < 32; b++) begin
            if ((k >> b) != 0) begin
                m = m | (32'h1 << b);
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] seed_guard(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/lane_perm_lfsr.sv
// 32-bit right-shifting Galois LFSR with seed load, advance and zero-seed guard.
module lane_perm_lfsr
    import lane_perm_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'h1,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      seed,
    input  logic             adv,
    output logic [OUT_W-1:0] bits
);

    logic [31:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed_guard(SEED);
        end else if (load) begin
            state_q <= seed_guard(seed);
        end else if (adv) begin
            state_q <= (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : 32'h0);
        end
    end

    assign bits = state_q[OUT_W-1:0];

endmodule

// File: rtl/lane_permuter.sv
// Registered lane crossbar (bypass/rotate/permute/inverse) with an on-chip
// Fisher-Yates map generator that swaps in a new map without stalling traffic.
module lane_permuter
    import lane_perm_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 16,
    parameter int unsigned LANE_WIDTH = 1360,
    parameter logic [31:0] SEED       = 32'h1,
    parameter int unsigned IDX_W      = $clog2(NUM_LANES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [LANE_WIDTH-1:0] i_data [NUM_LANES],
    input  logic [1:0]            i_mode,
    input  logic [IDX_W-1:0]      i_rot,
    input  logic                  i_regen,
    input  logic                  i_seed_load,
    input  logic [31:0]           i_seed,
    output logic                  o_valid,
    output logic [LANE_WIDTH-1:0] o_data [NUM_LANES],
    output logic                  o_busy,
    output logic [IDX_W-1:0]      o_map  [NUM_LANES]
);

    typedef logic [IDX_W-1:0] idx_t;

    gen_state_t state_q;
    idx_t       map_q    [NUM_LANES];
    idx_t       shadow_q [NUM_LANES];
    idx_t       k_q;
    logic       auto_q;
    logic       busy_q;

    idx_t lfsr_bits;
    idx_t mask;
    idx_t r;
    idx_t j_sel;
    idx_t inv  [NUM_LANES];
    idx_t sel  [NUM_LANES];

    lane_perm_lfsr #(
        .SEED  (SEED),
        .OUT_W (IDX_W)
    ) u_lfsr (
        .clk  (i_clk),
        .rst  (i_rst),
        .load (state_q == StIdle && i_seed_load),
        .seed (i_seed),
        .adv  (state_q == StShuf),
        .bits (lfsr_bits)
    );

    // Swap partner for the current k; folding keeps j inside 0..k.
    always_comb begin
        mask  = idx_t'(idx_mask(32'(k_q)));
        r     = lfsr_bits & mask;
        j_sel = (r > k_q) ? (r - k_q - idx_t'(1)) : r;
    end

    always_comb begin
        for (int p = 0; p < NUM_LANES; p++) begin
            inv[p] = '0;
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            inv[map_q[j]] = idx_t'(j);
        end
    end

    // Inverse mode is expressed as a gather through the inverted map.
    always_comb begin
        for (int j = 0; j < NUM_LANES; j++) begin
            sel[j] = idx_t'(j);
            case (mode_t'(i_mode))
                BYPASS:  sel[j] = idx_t'(j);
                ROTATE:  sel[j] = idx_t'((32'(j) + 32'(i_rot)) % NUM_LANES);
                PERMUTE: sel[j] = map_q[j];
                INVERSE: sel[j] = inv[j];
                default: sel[j] = idx_t'(j);
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            for (int j = 0; j < NUM_LANES; j++) begin
                o_data[j] <= '0;
            end
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                for (int j = 0; j < NUM_LANES; j++) begin
                    o_data[j] <= i_data[sel[j]];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            auto_q  <= 1'b1;
            k_q     <= '0;
            for (int j = 0; j < NUM_LANES; j++) begin
                map_q[j]    <= idx_t'(j);
                shadow_q[j] <= idx_t'(j);
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (auto_q || i_regen) begin
                        state_q <= StInit;
                        busy_q  <= 1'b1;
                        auto_q  <= 1'b0;
                    end
                end
                StInit: begin
                    for (int j = 0; j < NUM_LANES; j++) begin
                        shadow_q[j] <= idx_t'(j);
                    end
                    k_q     <= idx_t'(NUM_LANES - 1);
                    state_q <= StShuf;
                end
                StShuf: begin
                    shadow_q[k_q]   <= shadow_q[j_sel];
                    shadow_q[j_sel] <= shadow_q[k_q];
                    k_q             <= k_q - idx_t'(1);
                    if (k_q == idx_t'(1)) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    for (int j = 0; j < NUM_LANES; j++) begin
                        map_q[j] <= shadow_q[j];
                    end
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_map  = map_q;

endmodule

// File: tb/tb_lane_permuter.sv
// Scoreboard bench: a TX instance (any mode) feeds an RX instance in inverse mode
// whose reset/regen/seed controls lag by one cycle, so RX always undoes TX's map.
module tb_lane_permuter;

    localparam int NL = 16;
    localparam int LW = 8;
    localparam int IW = 4;
    localparam logic [31:0] SEED = 32'h1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [LW-1:0] din [NL];
    logic [1:0]    mode = 2'd0;
    logic [IW-1:0] rot = '0;
    logic          regen = 1'b0;
    logic          seed_load = 1'b0;
    logic [31:0]   seed = '0;

    logic          a_valid;
    logic [LW-1:0] a_data [NL];
    logic          a_busy;
    logic [IW-1:0] a_map [NL];

    logic          rst_b = 1'b1;
    logic          regen_b = 1'b0;
    logic          sl_b = 1'b0;
    logic [31:0]   seed_b = '0;
    logic          b_valid;
    logic [LW-1:0] b_data [NL];
    logic          b_busy;
    logic [IW-1:0] b_map [NL];

    lane_permuter #(.NUM_LANES(NL), .LANE_WIDTH(LW), .SEED(SEED)) u_tx (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(din), .i_mode(mode),
        .i_rot(rot), .i_regen(regen), .i_seed_load(seed_load), .i_seed(seed),
        .o_valid(a_valid), .o_data(a_data), .o_busy(a_busy), .o_map(a_map)
    );

    lane_permuter #(.NUM_LANES(NL), .LANE_WIDTH(LW), .SEED(SEED)) u_rx (
        .i_clk(clk), .i_rst(rst_b), .i_valid(a_valid), .i_data(a_data), .i_mode(2'd3),
        .i_rot(4'd0), .i_regen(regen_b), .i_seed_load(sl_b), .i_seed(seed_b),
        .o_valid(b_valid), .o_data(b_data), .o_busy(b_busy), .o_map(b_map)
    );

    always @(posedge clk) begin
        rst_b   <= rst;
        regen_b <= regen;
        sl_b    <= seed_load;
        seed_b  <= seed;
    end

    int           n_pass = 0;
    int           n_tot = 0;
    bit           chk_en = 1'b0;
    int           m_active [NL];
    int           m_pending [NL];
    int           ref_map1 [NL];
    int           m_cnt = 0;
    bit           m_auto = 1'b1;
    logic [31:0]  m_lfsr = SEED;
    logic [127:0] last_exp = '0;
    logic [127:0] qa [$];
    logic [127:0] qb [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] pack_d(input logic [LW-1:0] a [NL]);
        logic [127:0] w;
        for (int j = 0; j < NL; j++) w[j*LW +: LW] = a[j];
        return w;
    endfunction

    function automatic logic [63:0] pack_m(input logic [IW-1:0] a [NL]);
        logic [63:0] w;
        for (int j = 0; j < NL; j++) w[j*IW +: IW] = a[j];
        return w;
    endfunction

    function automatic logic [63:0] pack_mi(input int a [NL]);
        logic [63:0] w;
        for (int j = 0; j < NL; j++) w[j*IW +: IW] = 4'(a[j]);
        return w;
    endfunction

    function automatic logic [63:0] pack_id();
        logic [63:0] w;
        for (int j = 0; j < NL; j++) w[j*IW +: IW] = 4'(j);
        return w;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    // Reference Fisher-Yates: draw from the LFSR, fold into 0..k, swap.
    task automatic model_gen();
        int sh [NL];
        int m, r, jj, t;
        for (int i = 0; i < NL; i++) sh[i] = i;
        for (int k = NL - 1; k >= 1; k--) begin
            m = 1;
            while (m < k) m = m * 2 + 1;
            r = int'(m_lfsr[3:0]) & m;
            jj = (r > k) ? r - k - 1 : r;
            t = sh[k]; sh[k] = sh[jj]; sh[jj] = t;
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_pending = sh;
    endtask

    task automatic tick();
        logic [LW-1:0] ea [NL];
        logic [LW-1:0] eb [NL];
        if (!rst && valid) begin
            for (int j = 0; j < NL; j++) begin
                case (mode)
                    2'd0: ea[j] = din[j];
                    2'd1: ea[j] = din[(j + int'(rot)) % NL];
                    2'd2: ea[j] = din[m_active[j]];
                    default: ea[m_active[j]] = din[j];
                endcase
            end
            if (mode == 2'd2) eb = din;
            else for (int j = 0; j < NL; j++) eb[m_active[j]] = ea[j];
            qa.push_back(pack_d(ea));
            qb.push_back(pack_d(eb));
        end
        @(posedge clk);
        if (rst) begin
            m_lfsr = (SEED == 32'h0) ? 32'h1 : SEED;
            for (int j = 0; j < NL; j++) m_active[j] = j;
            m_cnt = 0;
            m_auto = 1'b1;
            last_exp = '0;
        end else if (m_cnt == 0) begin
            if (seed_load) m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
            if (m_auto || regen) begin
                model_gen();
                m_cnt = 1;
                m_auto = 1'b0;
            end
        end else if (m_cnt == NL + 1) begin
            m_active = m_pending;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        #1;
        regen = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int cnt = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (a_busy) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        chk(name, 128'(cnt), 128'(NL + 1));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_cyc", 128'(a_busy), 128'(m_cnt != 0));
            chk("map_cyc", 128'(pack_m(a_map)), 128'(pack_mi(m_active)));
            if (a_valid) begin
                if (qa.size() == 0) begin
                    n_tot++;
                    $display("FAIL tx_unexpected: got valid word, expected none");
                end else begin
                    last_exp = qa.pop_front();
                    chk("tx_data", pack_d(a_data), last_exp);
                end
            end else begin
                chk("tx_hold", pack_d(a_data), last_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && b_valid) begin
            if (qb.size() == 0) begin
                n_tot++;
                $display("FAIL rx_unexpected: got valid word, expected none");
            end else begin
                chk("rx_loopback", pack_d(b_data), qb.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] seen;
        for (int j = 0; j < NL; j++) din[j] = LW'(j);

        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_valid", 128'(a_valid), 128'(0));
        chk("rst_data", pack_d(a_data), 128'(0));
        chk("rst_busy", 128'(a_busy), 128'(0));
        chk("rst_map", 128'(pack_m(a_map)), 128'(pack_id()));

        rst = 1'b0;
        count_busy("gen_busy_len");
        seen = '0;
        for (int j = 0; j < NL; j++) seen[a_map[j]] = 1'b1;
        chk("map_is_perm", 128'(seen), 128'(16'hffff));
        chk("map_vs_model", 128'(pack_m(a_map)), 128'(pack_mi(m_active)));
        ref_map1 = m_active;

        valid = 1'b1;
        mode = 2'd0;
        tick();
        chk("bypass_lane5", 128'(a_data[5]), 128'(5));
        mode = 2'd1;
        rot = 4'd1;
        tick();
        chk("rot1_lane15", 128'(a_data[15]), 128'(0));
        chk("rot1_lane0", 128'(a_data[0]), 128'(1));
        rot = 4'd15;
        tick();
        chk("rot15_lane0", 128'(a_data[0]), 128'(15));
        rot = 4'd0;
        tick();
        chk("rot0_lane7", 128'(a_data[7]), 128'(7));
        mode = 2'd2;
        tick();
        mode = 2'd3;
        tick();
        valid = 1'b0;
        tick();
        tick();

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        count_busy("reset2_busy_len");
        chk("reset_repro", 128'(pack_m(a_map)), 128'(pack_mi(ref_map1)));

        // Continuous stream across a regen; the second pulse lands while busy.
        mode = 2'd2;
        valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            for (int j = 0; j < NL; j++) din[j] = LW'($urandom);
            if (i == 4) begin
                regen = 1'b1;
                seed_load = 1'b1;
                seed = 32'hACE1_2468;
            end
            if (i == 9) regen = 1'b1;
            tick();
        end

        for (int i = 0; i < 1000; i++) begin
            valid = ($urandom_range(0, 7) != 0);
            for (int j = 0; j < NL; j++) din[j] = LW'($urandom);
            if (i == 500) begin
                regen = 1'b1;
                seed_load = 1'b1;
                seed = 32'h1234_5678;
            end
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Reset while the shuffle is at k=8.
        regen = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_map", 128'(pack_m(a_map)), 128'(pack_id()));
        chk("midrst_valid", 128'(a_valid), 128'(0));
        rst = 1'b0;
        count_busy("midrst_busy_len");
        chk("midrst_map_seed", 128'(pack_m(a_map)), 128'(pack_mi(ref_map1)));

        seed_load = 1'b1;
        seed = 32'h0;
        regen = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("seed0_map", 128'(pack_m(a_map)), 128'(pack_mi(ref_map1)));

        for (int i = 0; i < 4; i++) tick();
        chk("tx_queue_empty", 128'(qa.size()), 128'(0));
        chk("rx_queue_empty", 128'(qb.size()), 128'(0));
        chk("rx_map_sync", 128'(pack_m(b_map)), 128'(pack_mi(m_active)));
        chk("rx_idle", 128'(b_busy), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
